gpia_out_port: RTL

//   Write side of a GPIA I/O port. It holds the output latch (OUT) and the data-direction register (DDR) for WIDTH pins.
//   The processing element updates both through a registered-ack strobe bus.
//   OUT supports write, set, clear, toggle and timed-pulse operations.
//   out_o/ddr_o feed the pad drivers and the per-bit input mux, which reads OUT back when DDR=1.

---
 rtl/gpia_out_port.sv | 97 +++++++++
 1 files changed

// File: rtl/gpia_out_port.sv
// Write side of a GPIA I/O port: output latch, direction register and a
// timed-pulse engine, all updated through a registered-ack strobe bus.
module gpia_out_port #(
  parameter int WIDTH        = 8,
  parameter int PULSE_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stb_i,
  input  logic             we_i,
  input  logic [2:0]       adr_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic             ack_o,
  output logic [WIDTH-1:0] out_o,
  output logic [WIDTH-1:0] ddr_o,
  output logic             busy_o
);

  localparam int CNT_W = ($clog2(PULSE_CYCLES) > 0) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, PULSE = 1'b1} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] pm, pm_next;
  logic [WIDTH-1:0] out_bus, out_next, ddr_next;
  logic             acc, wr, pulse_wr, expire;

  // An access is taken only while no ack is outstanding, so a strobe held
  // until ack produces exactly one ack pulse.
  assign acc      = stb_i & ~ack_o;
  assign wr       = acc & we_i;
  assign pulse_wr = wr & (adr_i == 3'd5);
  assign expire   = (state == PULSE) & ~pulse_wr & (cnt == '0);
  assign busy_o   = (state == PULSE);

  always_comb begin
    out_bus = out_o;
    if (wr) begin
      case (adr_i)
        3'd0:    out_bus = dat_i;
        3'd1:    out_bus = out_o | dat_i;
        3'd2:    out_bus = out_o & ~dat_i;
        3'd3:    out_bus = out_o ^ dat_i;
        default: out_bus = out_o;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (pulse_wr)    state_next = PULSE;
    else if (expire) state_next = IDLE;
  end

  // Expiry applies the same-edge bus result first, then forces pulsed bits low.
  always_comb begin
    out_next = out_bus;
    pm_next  = pm;
    cnt_next = cnt;
    ddr_next = ddr_o;
    if (wr && (adr_i == 3'd4)) ddr_next = dat_i;
    if (pulse_wr) begin
      out_next = out_bus | dat_i;
      pm_next  = pm | dat_i;
      cnt_next = CNT_LOAD;
    end else if (expire) begin
      out_next = out_bus & ~pm;
      pm_next  = '0;
    end else if ((state == PULSE) && (cnt != '0)) begin
      cnt_next = cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_o <= 1'b0;
      out_o <= '0;
      ddr_o <= '0;
      pm    <= '0;
      cnt   <= '0;
    end else begin
      ack_o <= acc;
      out_o <= out_next;
      ddr_o <= ddr_next;
      pm    <= pm_next;
      cnt   <= cnt_next;
    end
  end

endmodule
